// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int OVS       = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divide-by-DIV tick generator with a synchronous restart.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    // A one-bit counter is kept for DIV=1 so the port widths stay legal; it never leaves 0.
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_last;

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: 16x oversampling, 3-sample majority vote, one-deep holding register.
// States: IDLE wait for low line | START verify start bit | DATA shift bits | STOP check stop bit | BREAK wait for line high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic       Signal_Rx,
    input  logic       Rx_Ack,
    output logic [7:0] Rx_Data,
    output logic       Rx_Valid,
    output logic       Rx_Overrun,
    output logic       Rx_Frame_Err,
    output logic       Rx_Busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx: CLK_FREQ too low for BAUD, clock divider would be zero");
    end
    if (OVS != 16) begin : g_ovs_check
        $error("uart_rx: only 16x oversampling is supported");
    end

    logic                 r_sync1;
    logic                 r_sync2;
    rx_state_t            r_state;
    logic [3:0]           r_samp;
    logic [2:0]           r_bit;
    logic                 r_s7;
    logic                 r_s8;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 r_frame_err;
    logic                 r_busy;

    logic w_line;
    logic w_tick;
    logic w_restart;
    logic w_maj;
    logic w_decide;

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= Signal_Rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line    = r_sync2;
    assign w_restart = (r_state == IDLE) && !w_line;
    assign w_maj     = (r_s7 & r_s8) | (r_s7 & w_line) | (r_s8 & w_line);
    assign w_decide  = w_tick && (r_samp == 4'd9);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .i_clk     (Sys_CLK),
        .i_rst     (Sys_RST),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_state     <= IDLE;
            r_samp      <= '0;
            r_bit       <= '0;
            r_s7        <= 1'b1;
            r_s8        <= 1'b1;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            if (Rx_Ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end

            if (w_tick) begin
                r_samp <= r_samp + 4'd1;
                if (r_samp == 4'd7) r_s7 <= w_line;
                if (r_samp == 4'd8) r_s8 <= w_line;
            end

            case (r_state)
                IDLE: begin
                    if (!w_line) begin
                        r_state <= START;
                        r_samp  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_decide) begin
                        if (!w_maj) begin
                            r_state <= DATA;
                            r_bit   <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'(DATA_BITS - 1)) r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_decide) begin
                        if (w_maj) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            // An ack landing on the same edge frees the slot, so nothing is lost.
                            if (r_valid && !Rx_Ack) r_overrun <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_line) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Rx_Data      = r_data;
    assign Rx_Valid     = r_valid;
    assign Rx_Overrun   = r_overrun;
    assign Rx_Frame_Err = r_frame_err;
    assign Rx_Busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DIV=1 (16 clocks per bit).
module tb_uart_rx;

    logic       Sys_CLK;
    logic       Sys_RST;
    logic       Signal_Rx;
    logic       Rx_Ack;
    logic [7:0] Rx_Data;
    logic       Rx_Valid;
    logic       Rx_Overrun;
    logic       Rx_Frame_Err;
    logic       Rx_Busy;

    int n_total = 0;
    int n_pass  = 0;
    int fe_cnt  = 0;

    uart_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000),
        .OVS      (16)
    ) dut (
        .Sys_CLK      (Sys_CLK),
        .Sys_RST      (Sys_RST),
        .Signal_Rx    (Signal_Rx),
        .Rx_Ack       (Rx_Ack),
        .Rx_Data      (Rx_Data),
        .Rx_Valid     (Rx_Valid),
        .Rx_Overrun   (Rx_Overrun),
        .Rx_Frame_Err (Rx_Frame_Err),
        .Rx_Busy      (Rx_Busy)
    );

    initial Sys_CLK = 1'b0;
    always #5 Sys_CLK = ~Sys_CLK;

    always @(negedge Sys_CLK) begin
        if (Rx_Frame_Err === 1'b1) fe_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Sys_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Line is left at the stop-bit level; ack_at_stop raises Rx_Ack exactly on the stop decision edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit ack_at_stop);
        Signal_Rx = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            Signal_Rx = d[i];
            cyc(16);
        end
        Signal_Rx = stop;
        if (ack_at_stop) begin
            cyc(12);
            Rx_Ack = 1'b1;
            cyc(1);
            Rx_Ack = 1'b0;
            cyc(3);
        end else begin
            cyc(16);
        end
    endtask

    task automatic ack_pulse();
        Rx_Ack = 1'b1;
        cyc(1);
        Rx_Ack = 1'b0;
    endtask

    initial begin
        Sys_RST   = 1'b1;
        Signal_Rx = 1'b1;
        Rx_Ack    = 1'b0;
        cyc(3);
        check("rst_data",    Rx_Data, 8'h00);
        check("rst_valid",   Rx_Valid, 0);
        check("rst_overrun", Rx_Overrun, 0);
        check("rst_fe",      Rx_Frame_Err, 0);
        check("rst_busy",    Rx_Busy, 0);
        Sys_RST = 1'b0;
        cyc(4);

        // 1: plain frame and handshake
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_valid",   Rx_Valid, 1);
        check("t1_data",    Rx_Data, 8'hA5);
        check("t1_fe",      fe_cnt, 0);
        check("t1_overrun", Rx_Overrun, 0);
        check("t1_busy",    Rx_Busy, 0);
        ack_pulse();
        check("t1_ack_clr", Rx_Valid, 0);
        check("t1_data_kept", Rx_Data, 8'hA5);
        cyc(5);

        // 2: 5-clock glitch is rejected
        Signal_Rx = 1'b0;
        cyc(5);
        Signal_Rx = 1'b1;
        cyc(2);
        check("t2_busy_in_start", Rx_Busy, 1);
        cyc(10);
        check("t2_busy_back", Rx_Busy, 0);
        check("t2_no_valid",  Rx_Valid, 0);
        check("t2_no_fe",     fe_cnt, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("t2_valid", Rx_Valid, 1);
        check("t2_data",  Rx_Data, 8'h3C);
        ack_pulse();
        check("t2_ack_clr", Rx_Valid, 0);
        cyc(5);

        // 3: bad stop bit followed by a held break
        send_frame(8'h11, 1'b0, 1'b0);
        cyc(400);
        check("t3_one_fe",     fe_cnt, 1);
        check("t3_no_valid",   Rx_Valid, 0);
        check("t3_data_kept",  Rx_Data, 8'h3C);
        check("t3_busy_break", Rx_Busy, 1);
        Signal_Rx = 1'b1;
        cyc(4);
        check("t3_busy_idle", Rx_Busy, 0);
        cyc(10);
        send_frame(8'h22, 1'b1, 1'b0);
        check("t3_valid", Rx_Valid, 1);
        check("t3_data",  Rx_Data, 8'h22);
        check("t3_fe_total", fe_cnt, 1);
        ack_pulse();
        cyc(5);

        // 4: overrun
        send_frame(8'h01, 1'b1, 1'b0);
        check("t4_first_data", Rx_Data, 8'h01);
        check("t4_first_ovr",  Rx_Overrun, 0);
        send_frame(8'h02, 1'b1, 1'b0);
        check("t4_data",    Rx_Data, 8'h02);
        check("t4_valid",   Rx_Valid, 1);
        check("t4_overrun", Rx_Overrun, 1);
        ack_pulse();
        check("t4_ack_valid",   Rx_Valid, 0);
        check("t4_ack_overrun", Rx_Overrun, 0);
        cyc(5);

        // 5: ack coincides with completion of the next byte
        send_frame(8'h55, 1'b1, 1'b0);
        check("t5_hold_valid", Rx_Valid, 1);
        check("t5_hold_data",  Rx_Data, 8'h55);
        send_frame(8'h7E, 1'b1, 1'b1);
        check("t5_data",    Rx_Data, 8'h7E);
        check("t5_valid",   Rx_Valid, 1);
        check("t5_overrun", Rx_Overrun, 0);
        ack_pulse();
        check("t5_ack_clr", Rx_Valid, 0);
        cyc(5);

        // 6: reset in the middle of bit 3
        send_frame(8'h9A, 1'b1, 1'b0);
        check("t6_pre_valid", Rx_Valid, 1);
        Signal_Rx = 1'b0;
        cyc(16);
        Signal_Rx = 1'b1;
        cyc(48 + 8);
        check("t6_busy_mid", Rx_Busy, 1);
        Sys_RST = 1'b1;
        cyc(1);
        Sys_RST = 1'b0;
        check("t6_rst_data",    Rx_Data, 8'h00);
        check("t6_rst_valid",   Rx_Valid, 0);
        check("t6_rst_overrun", Rx_Overrun, 0);
        check("t6_rst_fe",      Rx_Frame_Err, 0);
        check("t6_rst_busy",    Rx_Busy, 0);
        cyc(8 + 64 + 16);
        check("t6_remnant_valid", Rx_Valid, 0);
        check("t6_remnant_busy",  Rx_Busy, 0);
        check("t6_remnant_fe",    fe_cnt, 1);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("t6_valid", Rx_Valid, 1);
        check("t6_data",  Rx_Data, 8'hC3);
        ack_pulse();
        check("t6_ack_clr", Rx_Valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for 8N1 asynchronous UART frames on the board's Rx pin. It is the receive end of the link whose transmit side drives Signal_Tx.
- Oversamples the line at 16x baud, rejects glitches, and majority-votes each bit.
- Presents each received byte to the system logic through a one-deep holding register with a valid/ack handshake.
- Instantiated inside Uart_Top alongside the transmitter, clocked from Sys_CLK.

Parameters:
- CLK_FREQ, 50_000_000: Sys_CLK frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVS, 16: oversample factor, fixed at 16; other values are not supported.
- DIV, derived, CLK_FREQ/(BAUD*OVS) truncated: Sys_CLK cycles per sample tick. Elaboration must fail if DIV < 1.

Ports:
- Sys_CLK  in  1  system clock; all logic on the rising edge.
- Sys_RST  in  1  reset, synchronous, active-high.
- Signal_Rx  in  1  asynchronous serial input; idles high.
- Rx_Ack  in  1  consumer has taken Rx_Data; single-cycle pulse or level.
- Rx_Data  out  8  last received byte; valid while Rx_Valid=1.
- Rx_Valid  out  1  holding register full.
- Rx_Overrun  out  1  sticky; a byte was lost. Cleared by Rx_Ack or reset.
- Rx_Frame_Err  out  1  one-cycle pulse when the stop bit is sampled low.
- Rx_Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (Sys_RST=1 at a clock edge):
  - State goes to IDLE; tick counter, sample counter and bit counter clear.
  - Rx_Data=8'h00, Rx_Valid=0, Rx_Overrun=0, Rx_Frame_Err=0, Rx_Busy=0.
  - Both synchronizer flops load 1.
  - Reset mid-frame abandons the frame silently and raises no error.
- Input conditioning:
  - Two-flop synchronizer on Signal_Rx feeds all decisions; this adds 2 cycles of latency.
  - Tick generator pulses tick for one cycle every DIV Sys_CLK cycles. It free-runs but restarts at 0 on the IDLE->START transition.
- Sampling:
  - Each bit spans 16 ticks, numbered 0..15.
  - Samples are taken at ticks 7, 8 and 9; the bit value is the majority of the three.
  - The decision is made at tick 9.
- State machine:
  - IDLE: synchronized line = 0 -> START.
  - START: at the tick-9 decision, majority 0 -> DATA with bit index 0. Majority 1 -> IDLE (glitch rejected; no flags raised).
  - DATA: bits arrive LSB first into a shift register. After bit 7 is decided -> STOP.
  - STOP, majority 1: load Rx_Data; set Rx_Valid; -> IDLE.
    - Rx_Data, Rx_Valid and any Rx_Overrun update on the cycle after the tick-9 decision.
    - IDLE is entered at tick 9, so a new start bit is accepted about 7 ticks early; this tolerates baud mismatch.
  - STOP, majority 0: pulse Rx_Frame_Err for one cycle; discard the byte; leave Rx_Data and Rx_Valid unchanged; -> BREAK.
  - BREAK: stay until synchronized line = 1, then -> IDLE. A held-low line (break) therefore yields exactly one frame error, not a stream.
- Handshake:
  - Rx_Ack while Rx_Valid=1 clears Rx_Valid and Rx_Overrun on the next edge.
  - Rx_Ack while Rx_Valid=0 is ignored.
  - Byte completes while Rx_Valid=1 and no Rx_Ack that cycle: Rx_Data is overwritten with the new byte, Rx_Valid stays 1, Rx_Overrun is set.
  - Byte completes in the same cycle as Rx_Ack: the new byte loads, Rx_Valid stays 1, Rx_Overrun is not set.
- Widths: tick counter is clog2(DIV) bits, wrapping at DIV-1; sample counter is 4 bits; bit index is 3 bits.

Decomposition:
- Shared package uart_pkg, also used by the transmitter:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - Constants DATA_BITS=8 and OVS=16.
  - Function computing DIV from CLK_FREQ and BAUD.
- Natural sub-module: uart_baud_tick, the DIV counter with a restart input and a tick output. It is shared with the transmitter, which instantiates it with OVS=1.

Test Plan:
All scenarios use CLK_FREQ=1_600_000 and BAUD=100_000, so DIV=1 and each bit is 16 clocks.
1. Send 8'hA5 as 8N1 -> Rx_Valid rises and Rx_Data=8'hA5 within frame + 4 cycles; Rx_Frame_Err stays 0; Rx_Ack clears Rx_Valid the next cycle.
2. Drive a 5-clock low pulse on an idle line -> no Rx_Valid and no Rx_Frame_Err; Rx_Busy returns to 0 and a following 8'h3C frame is received correctly.
3. Send 8'h11 with the stop bit low, then hold the line low for 400 clocks -> exactly one Rx_Frame_Err pulse and Rx_Valid remains 0. After the line goes high, 8'h22 is received correctly.
4. Send 8'h01 then 8'h02 with no Rx_Ack -> Rx_Data=8'h02, Rx_Valid=1, Rx_Overrun=1; a single Rx_Ack clears both flags.
5. Assert Rx_Ack in the exact cycle the 8'h7E stop-bit decision completes while holding 8'h55 -> Rx_Data=8'h7E, Rx_Valid=1, Rx_Overrun=0.
6. Assert Sys_RST for 1 cycle mid-bit-3 of a frame -> all outputs reset; the frame remnant produces no valid byte; the next full 8'hC3 frame is received correctly.
